jtag_debug_sysclk_bridge: RTL and testbench

//  Downstream stage of the CPU JTAG debug TCK-domain shift logic. Carries the update-DR/IR

---
 rtl/jtag_dbg_pkg.sv | 20 ++
 rtl/jtag_dbg_sync_edge.sv | 42 ++++
 rtl/jtag_debug_sysclk_bridge.sv | 137 +++++++++++++
 tb/tb_jtag_debug_sysclk_bridge.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/jtag_dbg_pkg.sv
// ---------------------------------------------------------------------------
// jtag_dbg_pkg
// Shared definitions for the CPU JTAG debug clk-domain bridge:
//   - debug IR encodings selecting which OCI unit a capture is aimed at
//   - jdo bit positions used by the action/no-action decode
// ---------------------------------------------------------------------------
package jtag_dbg_pkg;

   localparam logic [1:0] IR_OCIMEM    = 2'd0;
   localparam logic [1:0] IR_TRACEMEM  = 2'd1;
   localparam logic [1:0] IR_BREAK     = 2'd2;
   localparam logic [1:0] IR_TRACECTRL = 2'd3;

   localparam int JDO_B37 = 37;
   localparam int JDO_B36 = 36;
   localparam int JDO_B35 = 35;
   localparam int JDO_B34 = 34;
   localparam int JDO_B15 = 15;

endpackage

// File: rtl/jtag_dbg_sync_edge.sv
// ---------------------------------------------------------------------------
// jtag_dbg_sync_edge
// Brings an asynchronous level into the clk domain through SYNC_DEPTH flops
// and produces a one-cycle pulse on each synchronized rising edge.
// All history resets to 1 so a level already high when reset releases is
// not mistaken for a new edge; a low must be seen first.
// Ports:
//   clk       in  1  sampling clock
//   reset     in  1  synchronous, active-high
//   async_in  in  1  level from another clock domain
//   rise_stb  out 1  high for one cycle per synchronized rising edge
// ---------------------------------------------------------------------------
module jtag_dbg_sync_edge #(
   parameter int SYNC_DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise_stb
);

   logic [SYNC_DEPTH-1:0] sync_q, sync_d;
   logic                  prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_DEPTH-2:0], async_in};
      prev_d = sync_q[SYNC_DEPTH-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise_stb = sync_q[SYNC_DEPTH-1] & ~prev_q;

endmodule

// File: rtl/jtag_debug_sysclk_bridge.sv
// ---------------------------------------------------------------------------
// jtag_debug_sysclk_bridge
// clk-domain side of the CPU JTAG debug shift logic. Synchronizes the
// update-DR / update-IR events, captures the shift register into jdo,
// latches the debug IR and decodes one-cycle action strobes for the OCI
// memory, trace and break units.
// Ports:
//   clk, reset                   CPU clock, synchronous active-high reset
//   ir_in[1:0]                   debug IR from TCK domain (stable while vs_uir high)
//   sr[37:0]                     TCK-domain shift register (stable after vs_udr rise)
//   vs_udr, vs_uir               update-DR / update-IR levels, async to clk
//   jdo[37:0]                    captured sr
//   take_action_* / take_no_action_*   one-cycle decode strobes, at most one high
// ---------------------------------------------------------------------------
module jtag_debug_sysclk_bridge
   import jtag_dbg_pkg::*;
#(
   parameter int SYNC_DEPTH = 2,
   parameter int JDO_WIDTH  = 38,
   parameter int IR_WIDTH   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IR_WIDTH-1:0]  ir_in,
   input  logic [JDO_WIDTH-1:0] sr,
   input  logic                 vs_udr,
   input  logic                 vs_uir,
   output logic [JDO_WIDTH-1:0] jdo,
   output logic                 take_action_ocimem_a,
   output logic                 take_action_ocimem_b,
   output logic                 take_no_action_ocimem_a,
   output logic                 take_action_tracemem_a,
   output logic                 take_action_tracemem_b,
   output logic                 take_no_action_tracemem_a,
   output logic                 take_action_break_a,
   output logic                 take_action_break_b,
   output logic                 take_action_break_c,
   output logic                 take_no_action_break_a,
   output logic                 take_no_action_break_b,
   output logic                 take_no_action_break_c,
   output logic                 take_action_tracectrl
);

   logic                 udr_stb, uir_stb;
   logic [JDO_WIDTH-1:0] jdo_q, jdo_d;
   logic [IR_WIDTH-1:0]  ir_q, ir_d;
   logic                 en_action_q, en_action_d;
   logic                 dec_en;
   logic                 j37, j36, j35, j34, j15;

   jtag_dbg_sync_edge #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync_udr (
      .clk      (clk),
      .reset    (reset),
      .async_in (vs_udr),
      .rise_stb (udr_stb)
   );

   jtag_dbg_sync_edge #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync_uir (
      .clk      (clk),
      .reset    (reset),
      .async_in (vs_uir),
      .rise_stb (uir_stb)
   );

   always_comb begin
      jdo_d       = udr_stb ? sr : jdo_q;
      ir_d        = uir_stb ? ir_in : ir_q;
      en_action_d = udr_stb;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         jdo_q       <= '0;
         ir_q        <= '0;
         en_action_q <= 1'b0;
      end else begin
         jdo_q       <= jdo_d;
         ir_q        <= ir_d;
         en_action_q <= en_action_d;
      end
   end

   assign jdo = jdo_q;

   // Gating with reset suppresses a strobe in the very cycle reset is raised,
   // so a capture interrupted by reset never reaches the OCI units.
   assign dec_en = en_action_q & ~reset;

   assign j37 = jdo_q[JDO_B37];
   assign j36 = jdo_q[JDO_B36];
   assign j35 = jdo_q[JDO_B35];
   assign j34 = jdo_q[JDO_B34];
   assign j15 = jdo_q[JDO_B15];

   always_comb begin
      take_action_ocimem_a      = 1'b0;
      take_action_ocimem_b      = 1'b0;
      take_no_action_ocimem_a   = 1'b0;
      take_action_tracemem_a    = 1'b0;
      take_action_tracemem_b    = 1'b0;
      take_no_action_tracemem_a = 1'b0;
      take_action_break_a       = 1'b0;
      take_action_break_b       = 1'b0;
      take_action_break_c       = 1'b0;
      take_no_action_break_a    = 1'b0;
      take_no_action_break_b    = 1'b0;
      take_no_action_break_c    = 1'b0;
      take_action_tracectrl     = 1'b0;
      if (dec_en) begin
         case (ir_q)
            IR_OCIMEM: begin
               take_action_ocimem_a    = ~j35 &  j34;
               take_no_action_ocimem_a = ~j35 & ~j34;
               take_action_ocimem_b    =  j35;
            end
            IR_TRACEMEM: begin
               take_action_tracemem_a    = ~j37 &  j36;
               take_no_action_tracemem_a = ~j37 & ~j36;
               take_action_tracemem_b    =  j37;
            end
            IR_BREAK: begin
               // j36/j35 select the break register, j37 selects write vs. read-only
               take_action_break_a    = ~j36 &  j37;
               take_no_action_break_a = ~j36 & ~j37;
               take_action_break_b    =  j36 & ~j35 &  j37;
               take_no_action_break_b =  j36 & ~j35 & ~j37;
               take_action_break_c    =  j36 &  j35 &  j37;
               take_no_action_break_c =  j36 &  j35 & ~j37;
            end
            default: begin
               take_action_tracectrl = j15;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_debug_sysclk_bridge.sv
module tb_jtag_debug_sysclk_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  ir_in;
   logic [37:0] sr;
   logic        vs_udr;
   logic        vs_uir;
   logic [37:0] jdo;
   logic        t_oa, t_ob, t_noa, t_ta, t_tb, t_nta;
   logic        t_ba, t_bb, t_bc, t_nba, t_nbb, t_nbc, t_tc;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [37:0] exp_jdo  = '0;

   // Strobe vector bit map (MSB first)
   localparam logic [12:0] S_NONE  = 13'h0000;
   localparam logic [12:0] S_OA    = 13'h1000;
   localparam logic [12:0] S_OB    = 13'h0400;
   localparam logic [12:0] S_TA    = 13'h0200;
   localparam logic [12:0] S_NBA   = 13'h0020;
   localparam logic [12:0] S_BC    = 13'h0004;
   localparam logic [12:0] S_NBC   = 13'h0002;
   localparam logic [12:0] S_TC    = 13'h0001;

   wire [12:0] stb = {t_oa, t_noa, t_ob, t_ta, t_nta, t_tb,
                      t_ba, t_nba, t_bb, t_nbb, t_bc, t_nbc, t_tc};

   always #5 clk = ~clk;

   jtag_debug_sysclk_bridge #(.SYNC_DEPTH(2), .JDO_WIDTH(38), .IR_WIDTH(2)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .ir_in                     (ir_in),
      .sr                        (sr),
      .vs_udr                    (vs_udr),
      .vs_uir                    (vs_uir),
      .jdo                       (jdo),
      .take_action_ocimem_a      (t_oa),
      .take_action_ocimem_b      (t_ob),
      .take_no_action_ocimem_a   (t_noa),
      .take_action_tracemem_a    (t_ta),
      .take_action_tracemem_b    (t_tb),
      .take_no_action_tracemem_a (t_nta),
      .take_action_break_a       (t_ba),
      .take_action_break_b       (t_bb),
      .take_action_break_c       (t_bc),
      .take_no_action_break_a    (t_nba),
      .take_no_action_break_b    (t_nbb),
      .take_no_action_break_c    (t_nbc),
      .take_action_tracectrl     (t_tc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full update-DR sequence: edge in, capture after 3 edges, one strobe cycle.
   task automatic do_udr(input string tag, input logic [37:0] sr_v, input logic [12:0] exp_stb);
      sr     = sr_v;
      vs_udr = 1'b1;
      tick();
      tick();
      chk({tag, "_jdo_pre"}, {26'd0, jdo}, {26'd0, exp_jdo});
      chk({tag, "_stb_pre"}, {51'd0, stb}, {51'd0, S_NONE});
      tick();
      exp_jdo = sr_v;
      chk({tag, "_jdo"}, {26'd0, jdo}, {26'd0, exp_jdo});
      chk({tag, "_stb"}, {51'd0, stb}, {51'd0, exp_stb});
      tick();
      chk({tag, "_stb_post"}, {51'd0, stb}, {51'd0, S_NONE});
      chk({tag, "_jdo_hold"}, {26'd0, jdo}, {26'd0, exp_jdo});
      vs_udr = 1'b0;
      repeat (3) tick();
   endtask

   task automatic do_uir(input logic [1:0] ir_v);
      ir_in  = ir_v;
      vs_uir = 1'b1;
      repeat (4) tick();
      vs_uir = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      reset  = 1'b1;
      vs_udr = 1'b1;
      vs_uir = 1'b0;
      ir_in  = 2'd0;
      sr     = 38'h3F_FFFF_FFFF;

      // 1: vs_udr high across reset release gives no capture or strobe
      repeat (3) tick();
      chk("rst_jdo", {26'd0, jdo}, 64'd0);
      chk("rst_stb", {51'd0, stb}, 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_high_stb", {51'd0, stb}, 64'd0);
         chk("hold_high_jdo", {26'd0, jdo}, 64'd0);
      end
      vs_udr = 1'b0;
      repeat (3) tick();

      // 2: OCIMEM action_a
      do_uir(2'd0);
      do_udr("ocimem_a", {2'b00, 2'b01, 34'h1_2345_6789}, S_OA);

      // 3: BREAK decodes
      do_uir(2'd2);
      do_udr("break_c",    {3'b111, 35'h1_1111_1111}, S_BC);
      do_udr("no_break_c", {3'b011, 35'h2_2222_2222}, S_NBC);
      do_udr("no_break_a", {3'b000, 35'h0_0000_0055}, S_NBA);

      // 4: TRACECTRL
      do_uir(2'd3);
      do_udr("tracectrl",    {4'b1010, 34'h0_0000_8000}, S_TC);
      do_udr("tracectrl_0",  {4'b0101, 34'h3_FFFF_7FFF}, S_NONE);

      // 5: update-IR and update-DR rise together; decode sees new IR
      ir_in  = 2'd1;
      vs_uir = 1'b1;
      do_udr("same_cycle", {2'b01, 36'hA_BCDE_F012}, S_TA);
      vs_uir = 1'b0;
      repeat (3) tick();

      // 6: reset in the strobe cycle suppresses it and clears state
      sr     = {2'b00, 2'b10, 34'h0_0F0F_0F0F};
      vs_udr = 1'b1;
      repeat (3) tick();
      reset = 1'b1;
      #1;
      chk("rst_mid_stb", {51'd0, stb}, 64'd0);
      tick();
      exp_jdo = '0;
      chk("rst_mid_jdo", {26'd0, jdo}, 64'd0);
      chk("rst_mid_stb2", {51'd0, stb}, 64'd0);
      reset = 1'b0;
      repeat (3) begin
         tick();
         chk("post_rst_stb", {51'd0, stb}, 64'd0);
      end
      vs_udr = 1'b0;
      repeat (3) tick();
      do_udr("after_rst_ob", {2'b10, 2'b10, 34'h2_AAAA_5555}, S_OB);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
